// File: rtl/sprite_scan_pkg.sv
// sprite_scan_pkg: shared constants, scan states and slot layout for the sprite line engine
package sprite_scan_pkg;
  localparam int NUM_SPRITES = 32;
  localparam int H_VISIBLE = 640;
  localparam int H_LAST = 799;
  localparam int V_VISIBLE = 480;
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} scan_state_t;
  typedef struct packed {
    logic [9:0] x;
    logic [4:0] id;
    logic [3:0] row;
  } slot_t;
endpackage

// File: rtl/sprite_attr_table.sv
// sprite_attr_table: 32-entry sprite attribute register file with a combinational scan read port
module sprite_attr_table
  import sprite_scan_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] sel,
  input  logic [9:0] wr_x,
  input  logic [8:0] wr_y,
  input  logic       pos_we,
  input  logic       attr_we,
  input  logic       wr_vis,
  input  logic [4:0] rd_idx,
  output logic [9:0] rd_x,
  output logic [8:0] rd_y,
  output logic       rd_vis
);
  logic [9:0] tx [NUM_SPRITES];
  logic [8:0] ty [NUM_SPRITES];
  logic       tv [NUM_SPRITES];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        tx[i] <= '0;
        ty[i] <= '0;
        tv[i] <= 1'b0;
      end
    end else begin
      if (pos_we) begin
        tx[sel] <= wr_x;
        ty[sel] <= wr_y;
      end
      if (attr_we) tv[sel] <= wr_vis;
    end
  assign rd_x = tx[rd_idx];
  assign rd_y = ty[rd_idx];
  assign rd_vis = tv[rd_idx];
endmodule

// File: rtl/sprite_scan.sv
// sprite_scan: per-line sprite selection during hblank and per-pixel priority lookup
module sprite_scan
  import sprite_scan_pkg::*;
#(
  parameter int NUM_SLOTS = 8,
  parameter int SPRITE_DIM = 16,
  parameter int V_TOTAL = 525
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] sprite_sel,
  input  logic [9:0] sprite_x,
  input  logic [8:0] sprite_y,
  input  logic       sprite_pos,
  input  logic       sprite_attr,
  input  logic       sprite_vis,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  output logic       spr_hit,
  output logic [4:0] spr_index,
  output logic [3:0] spr_col,
  output logic [3:0] spr_row,
  output logic       spr_overflow,
  output logic       scan_busy
);
  localparam int CW = $clog2(NUM_SLOTS + 1);
  localparam logic [CW-1:0] SLOTS_C = CW'(NUM_SLOTS);
  localparam logic [9:0] DIM10 = 10'(SPRITE_DIM);
  localparam logic [9:0] H_START = 10'(H_VISIBLE);
  localparam logic [9:0] H_END = 10'(H_LAST);
  localparam logic [9:0] V_VIS10 = 10'(V_VISIBLE);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  scan_state_t state;
  logic [4:0] idx;
  logic [9:0] next_line;
  slot_t pend [NUM_SLOTS];
  slot_t act [NUM_SLOTS];
  logic [CW-1:0] pend_cnt, act_cnt;
  logic pend_ovf, act_ovf;
  logic [9:0] rd_x;
  logic [8:0] rd_y;
  logic rd_vis;
  logic [9:0] dy;
  logic match;
  logic hit, show;
  slot_t win;
  logic [3:0] win_col;
  sprite_attr_table u_table (
    .clk     (clk),
    .reset   (reset),
    .sel     (sprite_sel),
    .wr_x    (sprite_x),
    .wr_y    (sprite_y),
    .pos_we  (sprite_pos),
    .attr_we (sprite_attr),
    .wr_vis  (sprite_vis),
    .rd_idx  (idx),
    .rd_x    (rd_x),
    .rd_y    (rd_y),
    .rd_vis  (rd_vis)
  );
  assign dy = next_line - {1'b0, rd_y};
  assign match = rd_vis && next_line >= {1'b0, rd_y} && dy < DIM10;
  // hcount == 640 restarts the scan from any state, so a glitch never leaves a stale pending set
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      next_line <= '0;
      pend_cnt <= '0;
      pend_ovf <= 1'b0;
      act_cnt <= '0;
      act_ovf <= 1'b0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        pend[s] <= '0;
        act[s] <= '0;
      end
    end else if (hcount == H_START) begin
      state <= SCAN;
      idx <= '0;
      next_line <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
      pend_cnt <= '0;
      pend_ovf <= 1'b0;
      for (int s = 0; s < NUM_SLOTS; s++) pend[s] <= '0;
    end else if (state == SCAN) begin
      if (match && pend_cnt < SLOTS_C) begin
        for (int s = 0; s < NUM_SLOTS; s++)
          if (CW'(s) == pend_cnt) pend[s] <= '{x: rd_x, id: idx, row: dy[3:0]};
        pend_cnt <= pend_cnt + 1'b1;
      end else if (match) pend_ovf <= 1'b1;
      idx <= idx + 5'd1;
      if (idx == 5'd31) state <= DONE;
    end else if (state == DONE && hcount == H_END) begin
      state <= IDLE;
      act <= pend;
      act_cnt <= pend_cnt;
      act_ovf <= pend_ovf;
    end
  // Descending walk so the lowest hitting slot is the last one assigned
  always_comb begin
    hit = 1'b0;
    win = '0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--)
      if (CW'(s) < act_cnt && hcount >= act[s].x && (hcount - act[s].x) < DIM10) begin
        hit = 1'b1;
        win = act[s];
      end
  end
  assign win_col = hcount[3:0] - win.x[3:0];
  assign show = hit && hcount < H_START && vcount < V_VIS10;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      spr_hit <= 1'b0;
      spr_index <= '0;
      spr_col <= '0;
      spr_row <= '0;
    end else begin
      spr_hit <= show;
      spr_index <= show ? win.id : '0;
      spr_col <= show ? win_col : '0;
      spr_row <= show ? win.row : '0;
    end
  assign spr_overflow = act_ovf;
  assign scan_busy = state == SCAN;
endmodule
